// File: rtl/boot_copy_pkg.sv
// boot_copy_pkg: state type and constants shared by the boot copy engine
package boot_copy_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} boot_copy_state_e;
  localparam int BOOT_WORD_BYTES = 4;
  localparam logic [31:0] TCM_BASE_ADDR = 32'h0000_0000;
endpackage

// File: rtl/boot_copy_engine.sv
// boot_copy_engine: copies the boot ROM image into the TCM, then enables core fetch
module boot_copy_engine
  import boot_copy_pkg::*;
#(
  parameter int Depth = 42,
  parameter int DataWidth = 32,
  parameter int RomAddrWidth = $clog2(Depth * 4),
  parameter int TcmAddrWidth = 32,
  parameter logic [TcmAddrWidth-1:0] TcmBaseAddr = TcmAddrWidth'(TCM_BASE_ADDR)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  output logic                       bootrom_req_o,
  output logic [RomAddrWidth-1:0]    bootrom_addr_o,
  input  logic [DataWidth-1:0]       bootrom_rdata_i,
  output logic                       tcm_req_o,
  output logic                       tcm_we_o,
  output logic [DataWidth/8-1:0]     tcm_be_o,
  output logic [TcmAddrWidth-1:0]    tcm_addr_o,
  output logic [DataWidth-1:0]       tcm_wdata_o,
  input  logic                       tcm_gnt_i,
  output logic                       busy_o,
  output logic                       boot_done_o,
  output logic                       core_fetch_en_o,
  output logic [DataWidth-1:0]       checksum_o,
  output logic [$clog2(Depth+1)-1:0] word_cnt_o
);
  localparam int IdxW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam int OffW = $clog2(BOOT_WORD_BYTES);
  boot_copy_state_e state, state_n;
  logic [IdxW-1:0] idx;
  logic [IdxW+OffW-1:0] offset;
  logic last, fire;
  assign offset = {idx, OffW'(0)};
  assign last = idx == IdxW'(Depth - 1);
  assign fire = state == WRITE && tcm_gnt_i;
  assign tcm_be_o = '1;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      idx <= '0;
      checksum_o <= '0;
      word_cnt_o <= '0;
    end else begin
      state <= state_n;
      if (fire) begin
        checksum_o <= checksum_o ^ bootrom_rdata_i;
        word_cnt_o <= word_cnt_o + CntW'(1);
        idx <= last ? idx : idx + IdxW'(1);
      end
    end
  end
  // ROM data stays valid through WRITE because no new read is issued until the grant
  always_comb begin
    state_n = state == IDLE ? (start_i ? READ : IDLE)
            : state == READ ? WRITE
            : state == WRITE ? (tcm_gnt_i ? (last ? DONE : READ) : WRITE)
            : DONE;
    bootrom_req_o = state == READ;
    bootrom_addr_o = state == READ ? RomAddrWidth'(offset) : '0;
    tcm_req_o = state == WRITE;
    tcm_we_o = state == WRITE;
    tcm_addr_o = state == WRITE ? TcmBaseAddr + TcmAddrWidth'(offset) : '0;
    tcm_wdata_o = state == WRITE ? bootrom_rdata_i : '0;
    busy_o = state == READ || state == WRITE;
    boot_done_o = state == DONE;
    core_fetch_en_o = state == DONE;
  end
endmodule

// File: tb/tb_boot_copy_engine.sv
// tb_boot_copy_engine: randomized checks of the boot copy engine against an image/trace model
module tb_boot_copy_engine;
  localparam int DEPTH = 42;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic start_i = 1'b0;
  logic bootrom_req_o;
  logic [7:0] bootrom_addr_o;
  logic [31:0] bootrom_rdata_i;
  logic tcm_req_o, tcm_we_o, tcm_gnt_i;
  logic [3:0] tcm_be_o;
  logic [31:0] tcm_addr_o, tcm_wdata_o, checksum_o;
  logic busy_o, boot_done_o, core_fetch_en_o;
  logic [5:0] word_cnt_o;
  logic start1 = 1'b0;
  logic gnt1;
  logic rom_req1;
  logic [1:0] rom_addr1;
  logic [31:0] rom_rdata1;
  logic tcm_req1, tcm_we1;
  logic [3:0] tcm_be1;
  logic [31:0] tcm_addr1, tcm_wdata1, checksum1;
  logic busy1, done1, fetch1;
  logic [0:0] cnt1;
  logic [31:0] rom [64];
  logic [31:0] rom1_word;
  int rom_reads, rom1_reads;
  int vectors = 0, miscompares = 0;
  int wr_idx = 0, stall = 0, gnt_mode = 0;
  logic prev_req = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_data;

  always #5 clk = ~clk;

  boot_copy_engine dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .bootrom_req_o(bootrom_req_o), .bootrom_addr_o(bootrom_addr_o), .bootrom_rdata_i(bootrom_rdata_i),
    .tcm_req_o(tcm_req_o), .tcm_we_o(tcm_we_o), .tcm_be_o(tcm_be_o), .tcm_addr_o(tcm_addr_o),
    .tcm_wdata_o(tcm_wdata_o), .tcm_gnt_i(tcm_gnt_i), .busy_o(busy_o), .boot_done_o(boot_done_o),
    .core_fetch_en_o(core_fetch_en_o), .checksum_o(checksum_o), .word_cnt_o(word_cnt_o)
  );

  boot_copy_engine #(.Depth(1), .TcmBaseAddr(32'h0010_0000)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start1),
    .bootrom_req_o(rom_req1), .bootrom_addr_o(rom_addr1), .bootrom_rdata_i(rom_rdata1),
    .tcm_req_o(tcm_req1), .tcm_we_o(tcm_we1), .tcm_be_o(tcm_be1), .tcm_addr_o(tcm_addr1),
    .tcm_wdata_o(tcm_wdata1), .tcm_gnt_i(gnt1), .busy_o(busy1), .boot_done_o(done1),
    .core_fetch_en_o(fetch1), .checksum_o(checksum1), .word_cnt_o(cnt1)
  );

  // ROM models: registered read, data held until the next request
  always @(posedge clk) begin
    if (rst_i) begin
      rom_reads <= 0;
      rom1_reads <= 0;
    end else begin
      if (bootrom_req_o) begin
        bootrom_rdata_i <= rom[bootrom_addr_o >> 2];
        rom_reads <= rom_reads + 1;
      end
      if (rom_req1) begin
        rom_rdata1 <= rom1_word;
        rom1_reads <= rom1_reads + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] xor_upto(input int n);
    logic [31:0] x = '0;
    for (int i = 0; i < n; i++) x ^= rom[i];
    return x;
  endfunction

  // One cycle: observe at the falling edge, compare the bus against the expected
  // write sequence, then choose the grant for the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (rst_i) begin
      wr_idx = 0;
      stall = 0;
      prev_req = 1'b0;
      prev_stall = 1'b0;
      return;
    end
    if (bootrom_req_o) check("rom_addr", bootrom_addr_o, 64'(wr_idx * 4));
    if (prev_stall) begin
      check("hold_req", tcm_req_o, 1'b1);
      check("hold_addr", tcm_addr_o, prev_addr);
      check("hold_data", tcm_wdata_o, prev_data);
    end
    if (tcm_req_o) begin
      check("we", tcm_we_o, 1'b1);
      check("be", tcm_be_o, 4'hf);
      check("cnt_live", word_cnt_o, 64'(wr_idx));
      check("ck_live", checksum_o, xor_upto(wr_idx));
      if (!prev_req) stall = gnt_mode == 1 ? int'($urandom_range(0, 5)) : 0;
    end
    tcm_gnt_i = gnt_mode == 0 || (gnt_mode == 1 && tcm_req_o && stall == 0);
    if (tcm_req_o && !tcm_gnt_i && stall > 0) stall--;
    if (tcm_req_o && tcm_gnt_i) begin
      check("wr_addr", tcm_addr_o, 64'(wr_idx * 4));
      check("wr_data", tcm_wdata_o, rom[wr_idx]);
      wr_idx++;
    end
    prev_req = tcm_req_o;
    prev_stall = tcm_req_o && !tcm_gnt_i;
    prev_addr = tcm_addr_o;
    prev_data = tcm_wdata_o;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic run_to_done();
    for (int i = 0; i < 3000 && !boot_done_o; i++) tick();
    check("done_reached", boot_done_o, 1'b1);
  endtask

  task automatic final_checks();
    check("writes", 64'(wr_idx), 64'(DEPTH));
    check("cnt_final", word_cnt_o, 64'(DEPTH));
    check("checksum", checksum_o, xor_upto(DEPTH));
    check("fetch_en", core_fetch_en_o, 1'b1);
    check("busy_done", busy_o, 1'b0);
    check("rom_reads", 64'(rom_reads), 64'(DEPTH));
  endtask

  initial begin
    logic seen;
    tcm_gnt_i = 1'b1;
    gnt1 = 1'b1;
    rom[0] = 32'h0000_0093;
    rom[1] = 32'h0010_0113;
    for (int i = 2; i < 64; i++) rom[i] = $urandom;
    rom1_word = $urandom;
    do_reset();
    check("rst_req", {bootrom_req_o, tcm_req_o, tcm_we_o, busy_o, boot_done_o, core_fetch_en_o}, 0);
    check("rst_addr", {tcm_addr_o, tcm_wdata_o}, 0);
    check("rst_ck", {checksum_o, 26'b0, word_cnt_o}, 0);

    // Idle after reset: nothing moves without start
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      seen |= bootrom_req_o | tcm_req_o | core_fetch_en_o;
    end
    check("idle_quiet", seen, 1'b0);

    // Zero-wait copy with the exact completion cycle
    do_reset();
    gnt_mode = 0;
    pulse_start();
    repeat (83) tick();
    check("done_early", boot_done_o, 1'b0);
    tick();
    check("done_c85", boot_done_o, 1'b1);
    final_checks();

    // Random grant stalls
    do_reset();
    gnt_mode = 1;
    pulse_start();
    run_to_done();
    final_checks();

    // Start re-pulsed during WRITE and in DONE
    do_reset();
    gnt_mode = 0;
    pulse_start();
    for (int i = 0; i < 10 && !tcm_req_o; i++) tick();
    pulse_start();
    run_to_done();
    pulse_start();
    repeat (10) tick();
    final_checks();
    check("stay_done", boot_done_o, 1'b1);

    // Reset while word 10 waits for a withheld grant, then a fresh copy
    do_reset();
    gnt_mode = 0;
    pulse_start();
    for (int i = 0; i < 200 && wr_idx < 10; i++) tick();
    gnt_mode = 2;
    tick();
    tick();
    tick();
    check("w10_pending", {tcm_req_o, tcm_addr_o}, {1'b1, 32'd40});
    rst_i = 1'b1;
    tick();
    check("abort_req", {bootrom_req_o, tcm_req_o, tcm_we_o, busy_o, boot_done_o, core_fetch_en_o}, 0);
    check("abort_bus", {tcm_addr_o, tcm_wdata_o}, 0);
    check("abort_ck", {checksum_o, 26'b0, word_cnt_o}, 0);
    rst_i = 1'b0;
    gnt_mode = 0;
    pulse_start();
    run_to_done();
    final_checks();

    // Single-word image at a non-zero TCM base
    do_reset();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("d1_rom_req", {rom_req1, rom_addr1, busy1}, {1'b1, 2'b00, 1'b1});
    tick();
    check("d1_wr", {tcm_req1, tcm_addr1, tcm_wdata1}, {1'b1, 32'h0010_0000, rom1_word});
    check("d1_not_done", done1, 1'b0);
    tick();
    check("d1_done", {done1, fetch1, tcm_req1, busy1}, {1'b1, 1'b1, 1'b0, 1'b0});
    check("d1_sum", {checksum1, cnt1}, {rom1_word, 1'b1});
    repeat (5) tick();
    check("d1_reads", 64'(rom1_reads), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/boot_copy_engine.md
Name: boot_copy_engine

Overview:
Initiator for the bootloader ROM read port. After reset and a start pulse, it reads every ROM word in order and writes each one into the instruction TCM through a req/gnt write port. It then raises the core fetch-enable so the core boots from the TCM copy. It also computes an XOR checksum of the image for debug and status readback.

Parameters:
Depth, 42, number of 32-bit words in the ROM image to copy (must be >= 1).
DataWidth, 32, ROM/TCM data width.
RomAddrWidth, $clog2(Depth*4), ROM byte-address width.
TcmAddrWidth, 32, TCM byte-address width.
TcmBaseAddr, 32'h0000_0000, TCM byte address receiving ROM word 0.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  single-cycle copy request
bootrom_req_o  out  1  ROM read strobe
bootrom_addr_o  out  RomAddrWidth  ROM byte address (word-aligned, [1:0]=0)
bootrom_rdata_i  in  DataWidth  ROM data, valid the cycle after req, stable until next req
tcm_req_o  out  1  TCM write request
tcm_we_o  out  1  write enable (=tcm_req_o)
tcm_be_o  out  DataWidth/8  byte enables, all ones
tcm_addr_o  out  TcmAddrWidth  TCM byte address
tcm_wdata_o  out  DataWidth  write data
tcm_gnt_i  in  1  TCM grant; a write completes in any cycle where req && gnt
busy_o  out  1  copy in progress
boot_done_o  out  1  copy complete (sticky)
core_fetch_en_o  out  1  core fetch enable
checksum_o  out  DataWidth  XOR of all copied words
word_cnt_o  out  $clog2(Depth+1)  words written so far

Behaviour:
- Reset (rst_i=1 at posedge): state IDLE. All outputs 0: req, we, addr, wdata, busy, done, fetch_en, checksum, word_cnt. A reset mid-copy aborts immediately; no TCM write is issued the following cycle.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: on start_i go to READ with word index idx=0.
- READ: bootrom_req_o=1 for exactly one cycle; bootrom_addr_o = idx*4. Next state is WRITE.
- WRITE: tcm_req_o=tcm_we_o=1, tcm_addr_o = TcmBaseAddr + idx*4, tcm_wdata_o = bootrom_rdata_i. ROM req stays 0 so rdata holds.
  - Hold all of these until tcm_gnt_i=1. A grant in the first WRITE cycle is legal.
  - On grant: checksum ^= rdata; word_cnt++.
  - If idx==Depth-1, go to DONE; otherwise idx++ and go to READ.
- Throughput: 2 cycles per word with zero-wait grant. Minimum copy time is 2*Depth cycles from the cycle after start_i to the last grant.
- DONE: boot_done_o=1 and core_fetch_en_o=1 starting the cycle after the final grant. The block stays in DONE until reset.
- busy_o=1 in READ and WRITE only.
- start_i is ignored in READ, WRITE and DONE. No restart without reset.
- Address arithmetic:
  - idx is $clog2(Depth)-bit.
  - ROM address = {idx,2'b00} zero-extended or truncated to RomAddrWidth.
  - TCM address is a modulo-2^TcmAddrWidth add.
- checksum_o and word_cnt_o are visible live during the copy and frozen in DONE.
- Unused or out-of-range ROM words are never read.

Decomposition:
- Package boot_copy_pkg holds:
  - the state enum type boot_copy_state_e (IDLE, READ, WRITE, DONE);
  - the constant BOOT_WORD_BYTES = 4;
  - the default TcmBaseAddr.
- Single module, no sub-module. The FSM, index counter and checksum register fit in one file.
- Benches instantiate the existing bootloader ROM as the ROM-side model.

Test Plan:
1. Default ROM image, tcm_gnt_i tied 1, start_i pulse at cycle 0 -> first TCM write: addr 0x0, data 32'h00000093; second write: addr 0x4, data 32'h00100113. Expect 42 writes in total, boot_done_o and core_fetch_en_o high at cycle 85, word_cnt_o=42.
2. Random grant stalls of 0-5 cycles per write -> every write's addr/wdata held stable while req && !gnt. No duplicate or missing writes; final checksum_o equals the software XOR of the 42 ROM words.
3. start_i re-pulsed during WRITE and again in DONE -> no restart. word_cnt_o continues 0..42 monotonically; the bus trace is identical to scenario 1.
4. rst_i asserted in WRITE of word 10, with the grant withheld -> next cycle all outputs 0 and state IDLE. A new start_i copies from word 0 with addr 0x0 and checksum starting from 0.
5. TcmBaseAddr=32'h0010_0000, Depth=1 -> a single ROM read at addr 0 and a single write to 0x0010_0000. boot_done_o rises 2 cycles after start_i with zero-wait grant.
6. No start_i for 100 cycles after reset -> bootrom_req_o, tcm_req_o and core_fetch_en_o remain 0 throughout.
